// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32IM pipeline
// Ports: CLK/RESET_N (async active-low); ID operand fields and use flags; EX rd, load,
// divide-entry pulse and taken-redirect; outputs are PC/IF-ID/ID-EX write enables,
// IF-ID/ID-EX/EX-MEM flushes and div_busy. Optional HAZARD_PERF_EN adds stall_cycles
// and flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int DIV_LATENCY  = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_is_div,
    input  logic        ex_branch_taken,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ifid_flush,
    output logic        idex_write_en,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        div_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);
    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DIV_WAIT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    logic [1:0] state, state_nx;
    logic [5:0] div_cnt, div_cnt_nx;
    logic [1:0] fl_cnt, fl_cnt_nx;
    logic       load_use, in_div, in_fl, div_last, div_start, stall_div, redirect, lu;

    assign load_use  = ex_mem_read && ex_rd != 5'd0 &&
                       ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    assign in_div    = state == DIV_WAIT;
    assign in_fl     = state == FLUSH;
    assign div_last  = in_div && div_cnt == 6'd1;
    assign div_start = state == RUN && ex_is_div;
    // EX is held from the divide's entry cycle until the cycle the counter reaches 1
    assign stall_div = div_start || (in_div && !div_last);
    assign redirect  = !in_div && !div_start && ex_branch_taken;
    assign lu        = state == RUN && !ex_is_div && !ex_branch_taken && load_use;

    always_comb begin
        pc_write_en   = RESET_N && !stall_div && !lu;
        ifid_write_en = RESET_N && !stall_div && !lu;
        idex_write_en = RESET_N && !stall_div;
        ifid_flush    = !RESET_N || redirect || in_fl;
        idex_flush    = !RESET_N || redirect || lu;
        exmem_flush   = !RESET_N || stall_div;
        div_busy      = RESET_N && stall_div;
    end

    always_comb begin
        state_nx   = state;
        div_cnt_nx = div_cnt;
        fl_cnt_nx  = fl_cnt;
        if (div_start) begin
            state_nx   = DIV_WAIT;
            div_cnt_nx = 6'(DIV_LATENCY - 1);
        end else if (in_div) begin
            div_cnt_nx = div_cnt - 6'd1;
            if (div_last) state_nx = RUN;
        end else if (redirect && FLUSH_CYCLES > 1) begin
            // also covers a nested redirect while already in FLUSH
            state_nx  = FLUSH;
            fl_cnt_nx = 2'(FLUSH_CYCLES - 1);
        end else if (in_fl) begin
            fl_cnt_nx = fl_cnt - 2'd1;
            if (fl_cnt == 2'd1) state_nx = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= RUN;
            div_cnt <= 6'd0;
            fl_cnt  <= 2'd0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_cnt_nx;
            fl_cnt  <= fl_cnt_nx;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, !pc_write_en};
            flush_events <= flush_events + {31'd0, redirect};
        end
    end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl (DIV_LATENCY=4, FLUSH_CYCLES=3)
module tb_pipeline_hazard_ctrl;
    // expected vector order: pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_flush, div_busy
    localparam logic [6:0] NORM = 7'b1101000;
    localparam logic [6:0] LU   = 7'b0001100;
    localparam logic [6:0] BR   = 7'b1111100;
    localparam logic [6:0] FL   = 7'b1111000;
    localparam logic [6:0] DV   = 7'b0000011;
    localparam logic [6:0] RST  = 7'b0010110;

    typedef struct {
        logic [6:0] v;
        string      n;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, ex_rd = 5'd0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
    logic       ex_is_div = 1'b0, ex_branch_taken = 1'b0;
    logic       pc_write_en, ifid_write_en, ifid_flush, idex_write_en;
    logic       idex_flush, exmem_flush, div_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_ctrl #(.DIV_LATENCY(4), .FLUSH_CYCLES(3)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .ex_is_div(ex_is_div),
        .ex_branch_taken(ex_branch_taken),
        .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en),
        .ifid_flush(ifid_flush),
        .idex_write_en(idex_write_en),
        .idex_flush(idex_flush),
        .exmem_flush(exmem_flush),
        .div_busy(div_busy)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [6:0] act;
            e   = q.pop_front();
            act = {pc_write_en, ifid_write_en, ifid_flush, idex_write_en,
                   idex_flush, exmem_flush, div_busy};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.n, act, e.v);
            end
        end
    end

    task automatic step(input logic rn, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic dv, input logic br,
                        input logic [6:0] ev, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        RESET_N = rn; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read = mr; ex_is_div = dv; ex_branch_taken = br;
        e.v = ev;
        e.n = nm;
        q.push_back(e);
    endtask

    task automatic idle(input logic [6:0] ev, input string nm);
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ev, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST, "rst_hold0");
        step(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, RST, "rst_hold1");
        idle(NORM, "run_first");
        idle(NORM, "run_idle");
        step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, LU,   "lu_rs2");
        idle(NORM, "lu_clear");
        step(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, LU,   "lu_rs1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, NORM, "lu_rd0");
        step(1'b1, 5'd0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NORM, "lu_nouse");
        step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, NORM, "lu_noload");
        step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, BR,   "br_over_lu");
        idle(FL, "flush_hold1");
        idle(FL, "flush_hold2");
        idle(NORM, "flush_done");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BR,   "br_outer");
        idle(FL, "nest_hold1");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BR,   "br_nested");
        idle(FL, "nest_hold2");
        idle(FL, "nest_hold3");
        idle(NORM, "nest_done");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DV,   "div_entry");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, DV,   "div_wait_br");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, DV,   "div_wait_ign");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, NORM, "div_release");
        idle(NORM, "div_after");
        step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, LU,   "ld_then_div");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, DV,   "ld_div_entry");
        idle(DV, "ld_div_w1");
        idle(DV, "ld_div_w2");
        idle(NORM, "ld_div_rel");
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, DV,   "mid_entry");
        idle(DV, "mid_w1");
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, RST,  "mid_reset");
        idle(NORM, "mid_run");
        idle(NORM, "mid_run2");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, LU, "perf_lu");
            idle(NORM, "perf_lu_clr");
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, BR, "perf_br");
            idle(FL, "perf_fl1");
            idle(FL, "perf_fl2");
        end
        idle(NORM, "perf_end");
        @(negedge CLK);
        #1;
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_cycles !== 32'd3) begin
            errors++;
            $display("FAIL stall_cycles: got %0d expected 3", stall_cycles);
        end
        checks++;
        if (flush_events !== 32'd2) begin
            errors++;
            $display("FAIL flush_events: got %0d expected 2", flush_events);
        end
`endif
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
